spi_fsm: RTL and testbench

SPI_FSM -- requirements
Module: spi_fsm

---
 rtl/spi_fsm_pkg.sv | 23 ++
 rtl/spi_fsm.sv | 113 +++++++++++
 tb/tb_spi_fsm.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_fsm_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   state_t                - 2-bit FSM state encoding (IDLE/SHIFT/DONE)
//   PARALLEL_WIDTH_DEFAULT - default frame width in bits
//   count_width()          - width of a counter that must hold 0..w
package spi_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int PARALLEL_WIDTH_DEFAULT = 8;

    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/spi_fsm.sv
// Serial-to-parallel frame receiver: shifts in PARALLEL_WIDTH bits MSB first, publishes the frame.
// Latency: parallel_out/parallel_ready valid the cycle after the edge sampling the last bit.
// Backpressure: none; serial_ready qualifies every bit, a gap mid-frame aborts the frame.
//
// Ports:
//   clk            in   system clock, rising edge
//   resetN         in   asynchronous reset, active-high (1 = reset) despite the name
//   serial_ready   in   bit-valid qualifier, serial_in sampled every edge while high
//   serial_in      in   serial data, frame MSB first
//   parallel_ready out  one-cycle pulse: parallel_out was just loaded with a frame
//   parallel_out   out  last completed frame, held between frames and through aborts
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int PARALLEL_WIDTH = PARALLEL_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      serial_ready,
    input  logic                      serial_in,
    output logic                      parallel_ready,
    output logic [PARALLEL_WIDTH-1:0] parallel_out
);

    localparam int W  = PARALLEL_WIDTH;
    localparam int CW = count_width(W);

    // Count value held while waiting for the final bit of a frame: the
    // IDLE/DONE entry already accounts for bit 1, so bit W arrives when
    // count == W-1.
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t          state;
    logic [CW-1:0]   count;
    logic [W-1:0]    shreg;
    logic [W-1:0]    frame_next;

    // The shift register always holds the most recent accepted bits, so
    // on the last bit of a frame its low W-1 bits plus serial_in are
    // exactly the frame (frames are contiguous by construction: any gap
    // aborts).
    assign frame_next = {shreg[W-2:0], serial_in};

    // The oldest bit falls off the top of the shift register and is never
    // consumed; named so the intent is explicit.
    logic shreg_msb_unused;
    assign shreg_msb_unused = shreg[W-1];

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state          <= IDLE;
            count          <= '0;
            shreg          <= '0;
            parallel_out   <= '0;
            parallel_ready <= 1'b0;
        end else begin
            // The shifter runs in every state, independent of the FSM, so
            // the bit accepted in DONE is already in place for the next frame.
            if (serial_ready) begin
                shreg <= frame_next;
            end

            // Pulse output: only the completing edge raises it.
            parallel_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (serial_ready) begin
                        count <= ONE;
                        state <= SHIFT;
                    end else begin
                        count <= '0;
                    end
                end

                SHIFT: begin
                    if (!serial_ready) begin
                        // Gap inside a frame: drop it, keep the old output.
                        count <= '0;
                        state <= IDLE;
                    end else if (count == LAST_CNT) begin
                        parallel_out   <= frame_next;
                        parallel_ready <= 1'b1;
                        count          <= '0;
                        state          <= DONE;
                    end else begin
                        count <= count + ONE;
                    end
                end

                DONE: begin
                    // A bit arriving here is bit 1 of the next frame, which
                    // is what makes back-to-back frames lossless.
                    if (serial_ready) begin
                        count <= ONE;
                        state <= SHIFT;
                    end else begin
                        count <= '0;
                        state <= IDLE;
                    end
                end

                default: begin
                    // Unused encoding 2'b11 falls back to IDLE.
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm (PARALLEL_WIDTH = 8): directed scenarios plus
// randomized bit streams compared each cycle against a queue-based frame model.
module tb_spi_fsm;
    import spi_fsm_pkg::*;

    localparam int W = 8;

    logic          clk;
    logic          resetN;
    logic          serial_ready;
    logic          serial_in;
    logic          parallel_ready;
    logic [W-1:0]  parallel_out;

    spi_fsm #(.PARALLEL_WIDTH(W)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .serial_ready   (serial_ready),
        .serial_in      (serial_in),
        .parallel_ready (parallel_ready),
        .parallel_out   (parallel_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bits of the frame in progress, in arrival order.
    logic          model_q[$];
    logic [W-1:0]  exp_out;
    logic          exp_pulse;
    state_t        exp_state;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;
    int pulse_cycles[$];

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %b want %b", tag, obs, expv);
        end
    endtask

    task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check_bit({tag, ".ready"}, parallel_ready, exp_pulse);
        check_vec({tag, ".out"}, parallel_out, exp_out);
        check_int({tag, ".state"}, int'(dut.state), int'(exp_state));
    endtask

    // Frame-level model: a frame is W consecutive qualified bits; any gap
    // discards what has been collected. First bit lands in the MSB.
    task automatic model_cycle(input logic rdy, input logic b);
        exp_pulse = 1'b0;
        if (rdy) begin
            model_q.push_back(b);
            if (model_q.size() == W) begin
                for (int i = 0; i < W; i++) exp_out[W-1-i] = model_q[i];
                exp_pulse = 1'b1;
                model_q.delete();
            end
        end else begin
            model_q.delete();
        end
        if (exp_pulse)               exp_state = DONE;
        else if (model_q.size() > 0) exp_state = SHIFT;
        else                         exp_state = IDLE;
    endtask

    // Called at posedge+1: drive, advance one edge, sample at posedge+1.
    task automatic step(input string tag, input logic rdy, input logic b);
        serial_ready = rdy;
        serial_in    = b;
        @(posedge clk);
        #1;
        cyc++;
        model_cycle(rdy, b);
        if (parallel_ready) pulse_cycles.push_back(cyc);
        check_all(tag);
    endtask

    task automatic send_frame(input string tag, input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) step(tag, 1'b1, v[i]);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0);
    endtask

    // Reset pulsed between edges; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        resetN = 1'b1;
        #2;
        model_q.delete();
        exp_out   = '0;
        exp_pulse = 1'b0;
        exp_state = IDLE;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        resetN = 1'b0;
        check_all({tag, ".held"});
    endtask

    logic [W-1:0] rv;

    initial begin
        serial_ready = 1'b0;
        serial_in    = 1'b0;
        resetN       = 1'b0;
        exp_out      = '0;
        exp_pulse    = 1'b0;
        exp_state    = IDLE;
        #1;
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        resetN = 1'b0;

        // No traffic after reset: nothing happens.
        idle_cycles("quiet", 20);
        check_vec("quiet_out", parallel_out, 8'h00);

        // Alternating bits 0,1,... -> 8'h55, pulse in DONE.
        pulse_cycles.delete();
        send_frame("f55", 8'h55);
        check_bit("f55_pulse", parallel_ready, 1'b1);
        check_vec("f55_out", parallel_out, 8'h55);
        check_int("f55_state", int'(dut.state), int'(DONE));
        idle_cycles("f55_gap", 2);
        check_int("f55_count", pulse_cycles.size(), 1);

        // Back-to-back frames with serial_ready held high.
        pulse_cycles.delete();
        send_frame("fAC", 8'hAC);
        check_vec("fAC_out", parallel_out, 8'hAC);
        send_frame("f0F", 8'h0F);
        check_vec("f0F_out", parallel_out, 8'h0F);
        idle_cycles("b2b_gap", 1);
        check_int("b2b_pulses", pulse_cycles.size(), 2);
        if (pulse_cycles.size() == 2)
            check_int("b2b_spacing", pulse_cycles[1] - pulse_cycles[0], W);

        // Abort after 5 bits, then a full 8'h3C frame.
        pulse_cycles.delete();
        for (int i = 0; i < 5; i++) step("abort", 1'b1, 1'(i & 1));
        idle_cycles("abort_gap", 1);
        check_vec("abort_hold", parallel_out, 8'h0F);
        send_frame("f3C", 8'h3C);
        check_vec("f3C_out", parallel_out, 8'h3C);
        check_int("abort_pulses", pulse_cycles.size(), 1);
        idle_cycles("f3C_gap", 1);

        // Reset mid-frame, then a full 8'hFF frame.
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 1'b1);
        do_reset("midrst");
        send_frame("fFF", 8'hFF);
        check_vec("fFF_out", parallel_out, 8'hFF);

        // Randomized streams with occasional gaps and resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
            step("rnd", ($urandom_range(0, 11) != 0), 1'($urandom));
        end

        // A few random whole frames, each with a trailing gap.
        for (int n = 0; n < 10; n++) begin
            rv = W'($urandom);
            send_frame("rfrm", rv);
            check_vec("rfrm_out", parallel_out, rv);
            idle_cycles("rfrm_gap", $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
